// File: rtl/mod_sqr_iter.sv
`default_nettype none
// ============================================================================
// Module   : mod_square / mod_sqr_iter
// Brief    : GF(2^257) squarer (f = x^257 + x^12 + 1) and iterated-squaring
//            engine computing din^(2^k) mod f behind valid/ready handshakes.
// Revision : 1.0 - initial release
// ============================================================================

module mod_square (
  input  logic [256:0] a,
  output logic [256:0] y
);

  localparam int c_m = 257;

  // a_i lands on x^(2i); high terms fold back through x^257 = x^12 + 1, and
  // terms above x^501 fold a second time into the low even bits.
  generate
    for (genvar b = 0; b < c_m; b++) begin : g_bit
      if (b % 2 == 0) begin : g_even
        if (b <= 10) begin : g_lo
          assign y[b] = a[b/2] ^ a[b/2 + 251];
        end else if (b <= 22) begin : g_mid
          assign y[b] = a[b/2] ^ a[b/2 + 245];
        end else begin : g_hi
          assign y[b] = a[b/2];
        end
      end else begin : g_odd
        if (b < 13) begin : g_lo
          assign y[b] = a[(b + 257)/2];
        end else begin : g_hi
          assign y[b] = a[(b + 257)/2] ^ a[(b + 245)/2];
        end
      end
    end
  endgenerate

endmodule

module mod_sqr_iter #(
  parameter int M            = 257,
  parameter int CNT_W        = 9,
  parameter int SQ_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [M-1:0]     din,
  input  logic [CNT_W-1:0] k,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [M-1:0]     dout,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_p_cnt = CNT_W'(SQ_PER_CYCLE);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [M-1:0]     r_acc;
  logic [CNT_W-1:0] r_rem;
  logic [CNT_W-1:0] w_step;
  logic [CNT_W-1:0] w_rem_nxt;
  logic [M-1:0]     w_tap  [0:SQ_PER_CYCLE];
  logic [M-1:0]     w_pick [0:SQ_PER_CYCLE];

  assign w_tap[0]  = r_acc;
  assign w_pick[0] = '0;

  generate
    for (genvar i = 0; i < SQ_PER_CYCLE; i++) begin : g_sq
      mod_square u_sq (
        .a (w_tap[i]),
        .y (w_tap[i+1])
      );
    end
    // One-hot select of the tap after the w_step-th squarer
    for (genvar i = 1; i <= SQ_PER_CYCLE; i++) begin : g_sel
      assign w_pick[i] = w_pick[i-1] |
                         ((w_step == CNT_W'(i)) ? w_tap[i] : {M{1'b0}});
    end
  endgenerate

  assign w_step    = (r_rem < c_p_cnt) ? r_rem : c_p_cnt;
  assign w_rem_nxt = r_rem - w_step;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (in_valid) w_state_nxt = (k == '0) ? S_DONE : S_RUN;
      S_RUN:  if (w_rem_nxt == '0) w_state_nxt = S_DONE;
      S_DONE: if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_rem <= '0;
    end else if (r_state == S_IDLE && in_valid) begin
      r_acc <= din;
      r_rem <= k;
    end else if (r_state == S_RUN) begin
      r_acc <= w_pick[SQ_PER_CYCLE];
      r_rem <= w_rem_nxt;
    end
  end

  assign in_ready  = (r_state == S_IDLE) & rst_n;
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign dout      = r_acc;

endmodule
`default_nettype wire

// File: tb/tb_mod_sqr_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mod_sqr_iter
// Brief    : Checks mod_sqr_iter for P = 1, 2, 4 against a polynomial model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mod_sqr_iter;

  localparam int M = 257;
  localparam int CNT_W = 9;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [M-1:0]     din = '0;
  logic [CNT_W-1:0] k = '0;
  logic [2:0]       ir, ov, bz;
  logic [M-1:0]     dq0, dq1, dq2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mod_sqr_iter #(.M(M), .CNT_W(CNT_W), .SQ_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
    .din(din), .k(k), .out_valid(ov[0]), .out_ready(out_ready),
    .dout(dq0), .busy(bz[0]));
  mod_sqr_iter #(.M(M), .CNT_W(CNT_W), .SQ_PER_CYCLE(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
    .din(din), .k(k), .out_valid(ov[1]), .out_ready(out_ready),
    .dout(dq1), .busy(bz[1]));
  mod_sqr_iter #(.M(M), .CNT_W(CNT_W), .SQ_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]),
    .din(din), .k(k), .out_valid(ov[2]), .out_ready(out_ready),
    .dout(dq2), .busy(bz[2]));

  task automatic check_eq(input string tag, input logic [M-1:0] obs, input logic [M-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [M-1:0] dsel(input int d);
    return (d == 0) ? dq0 : (d == 1) ? dq1 : dq2;
  endfunction

  // Reference: schoolbook square, then long division by f bit by bit
  function automatic logic [M-1:0] gf_sq(input logic [M-1:0] a);
    logic [2*M-1:0] t;
    t = '0;
    for (int i = 0; i < M; i++) t[2*i] = a[i];
    for (int j = 2*M-2; j >= M; j--) begin
      if (t[j]) begin
        t[j]        = 1'b0;
        t[j-M]      = ~t[j-M];
        t[j-M+12]   = ~t[j-M+12];
      end
    end
    return t[M-1:0];
  endfunction

  function automatic logic [M-1:0] gf_pow2k(input logic [M-1:0] a, input int kk);
    logic [M-1:0] r;
    r = a;
    for (int i = 0; i < kk; i++) r = gf_sq(r);
    return r;
  endfunction

  function automatic logic [M-1:0] rand_elem();
    logic [M-1:0] r;
    r = '0;
    for (int w = 0; w < 9; w++) r = (r << 32) | M'($urandom);
    return r;
  endfunction

  // Issues one operation to all three engines; checks latency, result and release
  task automatic run_op(input logic [M-1:0] a, input int kk, input logic [M-1:0] exp);
    int first [3];
    int lat;
    int maxf;
    int w;
    w = 0;
    while (ir !== 3'b111 && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (ir !== 3'b111) check_eq("in_ready_wait", M'(ir), M'(3'b111));
    din = a; k = CNT_W'(kk); in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    first = '{-1, -1, -1};
    for (int n = 1; n <= 600; n++) begin
      @(negedge clk);
      in_valid = 1'b0;
      maxf = 0;
      for (int d = 0; d < 3; d++) begin
        lat = (kk + (1 << d) - 1) / (1 << d);
        if (first[d] < 0 && ov[d]) begin
          first[d] = n;
          check_eq($sformatf("latency_p%0d_k%0d", 1 << d, kk), M'(n), M'(lat + 1));
          check_eq($sformatf("dout_p%0d_k%0d", 1 << d, kk), dsel(d), exp);
        end else if (first[d] > 0 && n == first[d] + 1) begin
          check_eq($sformatf("release_p%0d", 1 << d), M'({bz[d], ov[d]}), M'(0));
        end
        if (first[d] < 0) maxf = 1000;
        else if (first[d] > maxf) maxf = first[d];
      end
      if (n > maxf) break;
    end
    for (int d = 0; d < 3; d++)
      if (first[d] < 0) check_eq($sformatf("timeout_p%0d", 1 << d), M'(0), M'(1));
  endtask

  initial begin : stim
    logic [M-1:0] a, e, snap;
    int kk, w;

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_in_ready", M'(ir), M'(0));
    check_eq("rst_out_valid", M'(ov), M'(0));
    check_eq("rst_busy", M'(bz), M'(0));
    check_eq("rst_dout", dq0 | dq1 | dq2, M'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Passthrough, single square, reduction, x^256
    run_op(M'(5), 0, M'(5));
    run_op(M'(2), 1, M'(4));
    e = '0; e[255] = 1'b1; e[22] = 1'b1; e[10] = 1'b1;
    run_op(M'(2), 9, e);
    e = '0; e[256] = 1'b1;
    run_op(M'(2), 8, e);
    a = rand_elem();
    run_op(a, 511, gf_pow2k(a, 511));

    // Frobenius period 257: result must equal the operand
    for (int t = 0; t < 100; t++) begin
      a = rand_elem();
      run_op(a, 257, a);
    end
    for (int t = 0; t < 20; t++) begin
      a = rand_elem();
      kk = $urandom_range(0, 511);
      run_op(a, kk, gf_pow2k(a, kk));
    end

    // Backpressure in DONE
    a = rand_elem();
    din = a; k = CNT_W'(5); in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    w = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      w++;
    end while (ov !== 3'b111 && w < 20);
    check_eq("bp_reach_done", M'(ov), M'(3'b111));
    snap = dq0;
    check_eq("bp_dout", snap, gf_pow2k(a, 5));
    for (int c = 0; c < 20; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      din = rand_elem();
      k = CNT_W'($urandom);
      @(negedge clk);
      check_eq("bp_stable", dq0, snap);
      check_eq("bp_stable_p4", dq2, snap);
      check_eq("bp_in_ready", M'(ir), M'(0));
      check_eq("bp_out_valid", M'(ov), M'(3'b111));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_release_ov", M'(ov), M'(0));
    check_eq("bp_release_ir", M'(ir), M'(3'b111));
    check_eq("bp_retained", dq1, snap);
    a = rand_elem();
    run_op(a, 3, gf_pow2k(a, 3));

    // Reset in the middle of RUN
    a = rand_elem();
    din = a; k = CNT_W'(300); in_valid = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    check_eq("mid_run_busy", M'(bz), M'(3'b111));
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("mrst_busy", M'(bz), M'(0));
    check_eq("mrst_out_valid", M'(ov), M'(0));
    check_eq("mrst_in_ready", M'(ir), M'(0));
    check_eq("mrst_dout", dq0 | dq1 | dq2, M'(0));
    @(negedge clk);
    check_eq("mrst_in_ready_hold", M'(ir), M'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_in_ready", M'(ir), M'(3'b111));
    a = rand_elem();
    kk = $urandom_range(1, 511);
    run_op(a, kk, gf_pow2k(a, kk));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
